fos_tdm_scheduler: RTL and testbench
====================================

Name: fos_tdm_scheduler

Overview:
- Time-division scheduler sharing one transposed-form first-order section (single 32x11 rad4_reference multiplier) between NCH independent channels.
- Arbitrates per-sample requests round-robin and holds a per-channel coefficient a1 and state sum0.
- Performs one filter update per granted sample.
- Emits results through a single registered output with valid/ready backpressure.

Parameters:
- NCH, 4: number of channels sharing the datapath (2..16).
- CHW, 2: channel index width, equal to clog2(NCH).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NCH  per-channel sample request; bit c set means x_in slice c is valid.
- x_in  input  NCH*32  per-channel samples; bits [32c+31:32c] belong to channel c.
- gnt  output  NCH  one-hot combinational grant; the sample of the granted channel is consumed this cycle.
- cfg_we  input  1  coefficient write strobe.
- cfg_ch  input  CHW  channel index for the coefficient write.
- cfg_a1  input  11  new a1 value, signed two's complement.
- y_out  output  32  filter output y of the reported channel.
- y_ch  output  CHW  channel index of y_out.
- y_valid  output  1  y_out and y_ch are valid.
- y_ready  input  1  downstream accepts y_out when y_valid and y_ready are both high.

Behaviour:
- Reset (synchronous, reset high at posedge):
  - All a1[c] = 0 and all sum0[c] = 0.
  - y_out = 0, y_ch = 0, y_valid = 0.
  - Round-robin pointer = 0, so channel 0 has highest priority on the first arbitration.
  - gnt = 0 while reset is high.
- Output slot free: slot_free = !y_valid || y_ready.
- Eligible set: req masked with slot_free. If cfg_we is high, bit cfg_ch is also removed from the set.
- Arbitration:
  - Round-robin: the first eligible channel at or after ptr, wrapping NCH-1 to 0.
  - After a grant to channel c, ptr becomes (c+1) mod NCH. If there is no grant, ptr is held.
  - At most one gnt bit is high. gnt is all-zero if the eligible set is empty.
- Requester rule: hold req and x_in stable until gnt is seen. Deasserting req before grant is allowed; that sample is simply dropped.
- Datapath, in the grant cycle for channel c (combinational, single shared multiplier):
  - y = sum0[c] + x_c, mod 2^32.
  - a1y = low 32 bits of the signed product y * a1[c], via one rad4_reference instance.
  - sum0_next = a1y - x_c, mod 2^32.
- Registers at the posedge ending the grant cycle:
  - sum0[c] <= sum0_next.
  - y_out <= y, y_ch <= c, y_valid <= 1.
- Latency: y_valid rises 1 cycle after the grant. Throughput is 1 sample/cycle across channels, including back-to-back grants to the same channel: the state update lands before the next grant, so no hazard.
- Backpressure:
  - y_valid && !y_ready: no grant; y_out and y_ch are held.
  - y_valid && y_ready with a new grant: output is replaced in the same cycle (no bubble).
  - y_valid && y_ready with no grant: y_valid <= 0.
- Coefficient write (cfg_we):
  - a1[cfg_ch] <= cfg_a1 and sum0[cfg_ch] <= 0 at the posedge.
  - The channel is masked from arbitration that cycle, so a write and a filter update never collide.
  - Writes to other channels do not disturb the granted channel.
- cfg_ch >= NCH: the write is ignored and nothing is masked.
- Reset mid-operation: a pending y_valid is dropped, all channel state and coefficients clear, and no grant is issued in the reset cycle.
- Overflow: no saturation anywhere; all wrap modulo 2^32.

Test Plan:
- Zero coefficient, passthrough: after reset, ch0 x=5 twice with y_ready=1 -> y_out=5 (sum0=0xFFFFFFFB), then y_out=0, y_ch=0.
- a1=2 recursion: write cfg ch1 a1=2; ch1 x=10, then x=0 -> y_out=10, then 10; sum0[1]=20; a third x=0 -> y_out=20.
- Negative coefficient: a1=11'h7FF (-1) on ch2; x=3, then x=0 -> y_out=3, then 0xFFFFFFFA.
- Round-robin fairness: req=4'b1111 held for 8 cycles, y_ready=1 -> gnt sequence ch0,1,2,3,0,1,2,3, y_valid high every cycle after the first, y_ch follows the grants.
- Backpressure: y_ready=0 for 3 cycles with y_valid=1 and req=4'b0011 -> gnt=0 and y_out/y_ch stable; y_ready=1 -> next grant in that cycle, new result on the following edge.
- Config collision and reset: cfg_we to ch0 while only ch0 requests -> gnt=0 that cycle, grant next cycle with sum0=0 and the new a1. reset asserted while y_valid=1 -> y_valid=0, y_out=0, and the next ch0 x=7 gives y_out=7.

Source files
------------

// File: rtl/fos_tdm_scheduler.sv
// Time-division scheduler sharing one transposed-form first-order section
// between NCH channels. Requests are granted round-robin. Each granted sample
// updates that channel's state, and the result is presented on a single
// registered valid/ready output.

// Signed 32x11 radix-4 Booth multiplier, low 32 bits of the product.
module rad4_reference (
  input  logic [31:0] a,
  input  logic [10:0] b,
  output logic [31:0] p
);

  // Sign-extended multiplier with the implicit zero below bit 0.
  logic [12:0] b_pad;
  logic [2:0]  trip;
  logic [31:0] pp;

  assign b_pad = {b[10], b, 1'b0};

  // Accumulate six Booth partial products modulo 2^32.
  always_comb begin
    p    = '0;
    trip = '0;
    pp   = '0;
    for (int i = 0; i < 6; i++) begin
      trip = b_pad[2*i +: 3];
      case (trip)
        3'b001, 3'b010: pp = a;
        3'b011:         pp = a << 1;
        3'b100:         pp = -(a << 1);
        3'b101, 3'b110: pp = -a;
        default:        pp = '0;
      endcase
      p = p + (pp << (2 * i));
    end
  end

endmodule

module fos_tdm_scheduler #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CHW = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCH-1:0]     req,
  input  logic [NCH*32-1:0]  x_in,
  output logic [NCH-1:0]     gnt,
  input  logic               cfg_we,
  input  logic [CHW-1:0]     cfg_ch,
  input  logic [10:0]        cfg_a1,
  output logic [31:0]        y_out,
  output logic [CHW-1:0]     y_ch,
  output logic               y_valid,
  input  logic               y_ready
);

  logic [10:0]    a1_q   [NCH];
  logic [31:0]    sum0_q [NCH];
  logic [CHW-1:0] ptr_q;

  logic           slot_free;
  logic           cfg_hit;
  logic [NCH-1:0] elig;
  logic           gnt_any;
  logic [CHW-1:0] gnt_idx;
  int unsigned    rr_idx;

  logic [31:0]    x_c;
  logic [31:0]    y;
  logic [31:0]    a1y;
  logic [31:0]    sum0_next;

  assign slot_free = !y_valid || y_ready;
  // Out-of-range channel writes are ignored entirely.
  assign cfg_hit   = cfg_we && (32'(cfg_ch) < NCH);

  // Eligible requesters: need a free output slot and no coefficient write this cycle.
  always_comb begin
    elig = req & {NCH{slot_free}};
    if (cfg_hit) begin
      elig[cfg_ch] = 1'b0;
    end
  end

  // Round-robin pick: first eligible channel at or after ptr, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    rr_idx  = 0;
    if (!reset) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        rr_idx = (32'(ptr_q) + k) % NCH;
        if (!gnt_any && elig[rr_idx[CHW-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = rr_idx[CHW-1:0];
        end
      end
      if (gnt_any) begin
        gnt[gnt_idx] = 1'b1;
      end
    end
  end

  // Shared datapath, steered by the granted channel.
  assign x_c       = x_in[gnt_idx*32 +: 32];
  assign y         = sum0_q[gnt_idx] + x_c;
  assign sum0_next = a1y - x_c;

  rad4_reference u_mul (
    .a (y),
    .b (a1_q[gnt_idx]),
    .p (a1y)
  );

  // Channel state, round-robin pointer and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        a1_q[c]   <= '0;
        sum0_q[c] <= '0;
      end
      ptr_q   <= '0;
      y_out   <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        // A written channel is masked from arbitration, so the two never collide.
        if (cfg_hit && (32'(cfg_ch) == c)) begin
          a1_q[c]   <= cfg_a1;
          sum0_q[c] <= '0;
        end else if (gnt[c]) begin
          sum0_q[c] <= sum0_next;
        end
      end
      if (gnt_any) begin
        y_out   <= y;
        y_ch    <= gnt_idx;
        y_valid <= 1'b1;
        ptr_q   <= (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + CHW'(1);
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fos_tdm_scheduler.sv
// Directed bench for fos_tdm_scheduler: a reference model predicts grants and
// results. Expected outputs are queued at grant time and popped after the edge.
module tb_fos_tdm_scheduler;

  localparam int NCH = 4;
  localparam int CHW = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NCH-1:0]    req = '0;
  logic [NCH*32-1:0] x_in = '0;
  logic [NCH-1:0]    gnt;
  logic              cfg_we = 1'b0;
  logic [CHW-1:0]    cfg_ch = '0;
  logic [10:0]       cfg_a1 = '0;
  logic [31:0]       y_out;
  logic [CHW-1:0]    y_ch;
  logic              y_valid;
  logic              y_ready = 1'b1;

  always #5 clk = ~clk;

  fos_tdm_scheduler #(.NCH(NCH), .CHW(CHW)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .x_in    (x_in),
    .gnt     (gnt),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_a1  (cfg_a1),
    .y_out   (y_out),
    .y_ch    (y_ch),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  int chk = 0;
  int errs = 0;

  typedef struct {
    logic [31:0] y;
    logic [1:0]  ch;
  } res_t;
  res_t sb[$];

  logic [10:0] m_a1  [NCH];
  logic [31:0] m_sum [NCH];
  logic [1:0]  m_ptr;
  logic        m_valid;
  logic [31:0] m_yout;
  logic [1:0]  m_ych;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] xv(input int c, input logic [31:0] v);
    logic [127:0] r;
    r = '0;
    r[32*c +: 32] = v;
    return r;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_a1[c]  = '0;
      m_sum[c] = '0;
    end
    m_ptr   = '0;
    m_valid = 1'b0;
    m_yout  = '0;
    m_ych   = '0;
    sb.delete();
  endtask

  // One clock of stimulus: predict and check the grant, then the registered output.
  task automatic step(input logic [3:0] r, input logic [127:0] x, input logic rdy,
                      input logic we, input logic [1:0] ch, input logic [10:0] a);
    logic [3:0]  eg;
    logic [3:0]  mg;
    int          c;
    logic [31:0] xc;
    logic [31:0] yy;
    longint      prod;
    res_t        e;
    req = r; x_in = x; y_ready = rdy; cfg_we = we; cfg_ch = ch; cfg_a1 = a;
    #1;
    eg = r & {4{(!m_valid || rdy)}};
    if (we) eg[ch] = 1'b0;
    c = -1;
    for (int k = 0; k < NCH; k++) begin
      int i;
      i = (int'(m_ptr) + k) % NCH;
      if (c < 0 && eg[i]) c = i;
    end
    mg = (c >= 0) ? (4'b0001 << c) : 4'b0000;
    check("gnt", 32'(gnt), 32'(mg));
    if (c >= 0) begin
      xc   = x[32*c +: 32];
      yy   = m_sum[c] + xc;
      prod = longint'($signed(yy)) * longint'($signed(m_a1[c]));
      m_sum[c] = prod[31:0] - xc;
      sb.push_back('{yy, 2'(c)});
      m_ptr = 2'((c + 1) % NCH);
    end
    if (we) begin
      m_a1[ch]  = a;
      m_sum[ch] = '0;
    end
    if (c >= 0) m_valid = 1'b1;
    else if (rdy) m_valid = 1'b0;
    @(posedge clk); #1;
    check("y_valid", 32'(y_valid), 32'(m_valid));
    if (c >= 0 && sb.size() > 0) begin
      e = sb.pop_front();
      m_yout = e.y;
      m_ych  = e.ch;
    end
    if (m_valid) begin
      check("y_out", y_out, m_yout);
      check("y_ch", 32'(y_ch), 32'(m_ych));
    end
  endtask

  task automatic do_reset(input logic [3:0] r);
    req = r; x_in = xv(0, 32'd99); y_ready = 1'b1; cfg_we = 1'b0; reset = 1'b1;
    #1;
    check("gnt_in_reset", 32'(gnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_y_out", y_out, 32'd0);
    check("rst_y_ch", 32'(y_ch), 32'd0);
  endtask

  initial begin
    model_clear();
    do_reset(4'b0000);

    // Zero coefficient: passthrough, state becomes -x.
    step(4'b0001, xv(0, 32'd5), 1'b1, 1'b0, 2'd0, 11'd0);
    check("t1_y_first", y_out, 32'd5);
    step(4'b0001, xv(0, 32'd5), 1'b1, 1'b0, 2'd0, 11'd0);
    check("t1_y_second", y_out, 32'd0);
    check("t1_y_ch", 32'(y_ch), 32'd0);

    // a1 = 2 recursion on channel 1.
    step(4'b0000, '0, 1'b1, 1'b1, 2'd1, 11'd2);
    step(4'b0010, xv(1, 32'd10), 1'b1, 1'b0, 2'd0, 11'd0);
    check("t2_y0", y_out, 32'd10);
    step(4'b0010, xv(1, 32'd0), 1'b1, 1'b0, 2'd0, 11'd0);
    check("t2_y1", y_out, 32'd10);
    step(4'b0010, xv(1, 32'd0), 1'b1, 1'b0, 2'd0, 11'd0);
    check("t2_y2", y_out, 32'd20);

    // Negative coefficient on channel 2.
    step(4'b0000, '0, 1'b1, 1'b1, 2'd2, 11'h7FF);
    step(4'b0100, xv(2, 32'd3), 1'b1, 1'b0, 2'd0, 11'd0);
    check("t3_y0", y_out, 32'd3);
    step(4'b0100, xv(2, 32'd0), 1'b1, 1'b0, 2'd0, 11'd0);
    check("t3_y1", y_out, 32'hFFFF_FFFA);

    // Round-robin fairness from a fresh pointer.
    do_reset(4'b1111);
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, {32'd40 + 32'(i), 32'd30, 32'd20, 32'd10}, 1'b1, 1'b0, 2'd0, 11'd0);
      check("rr_y_ch", 32'(y_ch), 32'(i % 4));
      check("rr_y_valid", 32'(y_valid), 32'd1);
    end

    // Backpressure: output held, no grants, then immediate replacement.
    for (int i = 0; i < 3; i++) begin
      step(4'b0011, {64'd0, 32'd22, 32'd11}, 1'b0, 1'b0, 2'd0, 11'd0);
      check("bp_gnt", 32'(gnt), 32'd0);
      check("bp_y_ch", 32'(y_ch), 32'd3);
    end
    step(4'b0011, {64'd0, 32'd22, 32'd11}, 1'b1, 1'b0, 2'd0, 11'd0);
    check("bp_release_ch", 32'(y_ch), 32'd0);
    step(4'b0000, '0, 1'b1, 1'b0, 2'd0, 11'd0);

    // Coefficient write collides with the only requester.
    step(4'b0001, xv(0, 32'd4), 1'b1, 1'b1, 2'd0, 11'd3);
    check("cfg_mask_gnt", 32'(gnt), 32'd0);
    step(4'b0001, xv(0, 32'd4), 1'b1, 1'b0, 2'd0, 11'd0);
    check("cfg_y0", y_out, 32'd4);
    step(4'b0001, xv(0, 32'd0), 1'b1, 1'b0, 2'd0, 11'd0);
    check("cfg_y1", y_out, 32'd8);

    // Reset while a result is pending.
    check("pre_reset_valid", 32'(y_valid), 32'd1);
    do_reset(4'b0001);
    step(4'b0001, xv(0, 32'd7), 1'b1, 1'b0, 2'd0, 11'd0);
    check("post_reset_y", y_out, 32'd7);
    check("post_reset_ch", 32'(y_ch), 32'd0);
    step(4'b0000, '0, 1'b1, 1'b0, 2'd0, 11'd0);

    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule
